fsb_master: RTL and testbench
=============================

FSB_MASTER -- requirements
Module: fsb_master

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, 8'd255, maximum wait clocks in WAIT/VPA before a forced bus error (legal range 1..255).
REQ-002 The ports SHALL be, one per line, name / direction / width / meaning:
- CLK_FSB  in  1  sole clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  1  request a bus cycle; sampled only in IDLE.
- RW  in  1  1 = read, 0 = write.
- BE  in  2  byte enables, [1] = upper, [0] = lower; 2'b00 is illegal and is not checked.
- ADDR  in  23  word address A[23:1].
- WDATA  in  16  write data.
- BUSY  out  1  high from request acceptance until return to IDLE.
- ACK  out  1  one-clock pulse on normal termination.
- ERR  out  1  one-clock pulse on BERR or timeout termination.
- RDATA  out  16  read data, valid in the ACK cycle and held until the next capture.
- A_out  out  23  bus address.
- D_out  out  16  bus write data.
- D_OE  out  1  write-data output enable.
- nAS_out, nUDS_out, nLDS_out, nWE_out, nVMA_out  out  1 each  bus strobes, active low.
- nDTACK_in, nVPA_in, nBERR_in  in  1 each  cycle terminations, active low, already synchronized to CLK_FSB.
- E_in  in  1  6800 E clock, already synchronized.
- D_in  in  16  bus read data.

Function
REQ-003 The states SHALL be IDLE, ADDR, STRB, WAIT, VPAW, VMA, TERM, RECOV, with exactly one state per clock except where a state waits.
REQ-004 In IDLE with REQ=1, the block SHALL, on the next edge, latch ADDR/RW/BE/WDATA, drive A_out and nWE_out=RW, set BUSY=1, and go to ADDR.
REQ-005 ADDR -> STRB: nAS_out=0; on a read, nUDS_out/nLDS_out = ~BE in the same cycle; D_OE=1 on a write.
REQ-006 STRB -> WAIT: on a write, the data strobes SHALL assert one clock after nAS_out.
REQ-007 Termination priority in WAIT SHALL be nBERR_in=0, then nDTACK_in=0, then nVPA_in=0.
- BERR (including when DTACK is low in the same sample): go to RECOV and pulse ERR.
- DTACK: go to TERM.
- VPA: go to VPAW.
REQ-008 VPAW SHALL wait for an E_in rising edge (registered E=0, current E=1), then assert nVMA_out=0 and go to VMA.
REQ-009 VMA SHALL wait for an E_in falling edge, then go to TERM.
REQ-010 TERM SHALL do all of the following:
- capture D_in into RDATA when the cycle is a read;
- negate nAS_out, nUDS_out, nLDS_out and nVMA_out;
- clear D_OE;
- pulse ACK;
- go to RECOV.
REQ-011 RECOV SHALL hold all strobes negated until nDTACK_in, nVPA_in and nBERR_in are all 1, then clear BUSY and go to IDLE.
REQ-012 The minimum cycle from REQ to ACK SHALL be 4 clocks for a read with DTACK already low (IDLE, ADDR, STRB, WAIT sampled, ACK in TERM).
REQ-013 An 8-bit timeout counter SHALL clear on entry to WAIT and increment each clock in WAIT/VPAW/VMA.
REQ-014 When the timeout counter reaches TIMEOUT, the block SHALL negate all strobes, pulse ERR and go to RECOV; the counter SHALL saturate and never wrap.
REQ-015 REQ asserted while BUSY=1 SHALL be ignored; a REQ held high through RECOV SHALL start a new cycle from IDLE.
REQ-016 ACK and ERR SHALL never assert in the same cycle.

Reset
REQ-017 With RESET=1 at an edge, the outputs SHALL take these values on that edge, whatever the current state (including mid-cycle):
- state = IDLE;
- nAS_out, nUDS_out, nLDS_out, nVMA_out, nWE_out = 1;
- D_OE = 0;
- BUSY, ACK, ERR = 0;
- RDATA = 0, A_out = 0, D_out = 0;
- timeout counter = 0.
REQ-018 No ACK or ERR SHALL be emitted for a cycle aborted by RESET.

Verification
REQ-019 Read cycle: REQ with RW=1, BE=2'b11, ADDR=23'h200000; nDTACK_in low from the STRB cycle; D_in=16'hA55A.
- Required: ACK on clock 4; RDATA=16'hA55A; nAS_out low for exactly 2 clocks.
REQ-020 Write cycle: RW=0, BE=2'b01, WDATA=16'h00C3; DTACK arrives 3 clocks late.
- Required: nLDS_out falls 1 clock after nAS_out; nUDS_out stays 1; D_OE=1 until TERM; ACK once.
REQ-021 VPA cycle: nVPA_in low, E_in with period 10.
- Required: nVMA_out falls on E rising; TERM follows E falling; ACK once; no ERR.
REQ-022 Simultaneous terminations: nBERR_in and nDTACK_in both low in WAIT.
- Required: ERR pulses; no ACK; RDATA unchanged.
REQ-023 Timeout: TIMEOUT=8, no termination ever asserted.
- Required: ERR exactly 8 clocks after WAIT entry; then RECOV -> IDLE with BUSY=0.
REQ-024 Reset mid-cycle: RESET asserted in WAIT.
- Required: all strobes = 1 on the next edge; BUSY=0; no ACK/ERR; a subsequent REQ completes normally.

Source files
------------

// File: rtl/fsb_master.sv
// 68000-style bus master sequencer.
// Runs one bus cycle per accepted request. Terminations are DTACK (normal),
// VPA (synchronous 6800 cycle through E), BERR, or a wait timeout.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no cycle in progress, REQ sampled here only
//   ADDR   | address and nWE driven, strobes still negated
//   STRB   | nAS low (read data strobes low too); write data strobes next
//   WAIT   | waiting for BERR / DTACK / VPA or the timeout
//   VPAW   | VPA seen, waiting for E rising to assert nVMA
//   VMA    | nVMA low, waiting for E falling
//   TERM   | strobes released, read data captured, ACK high this cycle
//   RECOV  | strobes negated until all terminations released, then IDLE
module fsb_master #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK_FSB,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        RW,
  input  logic [1:0]  BE,
  input  logic [22:0] ADDR,
  input  logic [15:0] WDATA,
  output logic        BUSY,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] A_out,
  output logic [15:0] D_out,
  output logic        D_OE,
  output logic        nAS_out,
  output logic        nUDS_out,
  output logic        nLDS_out,
  output logic        nWE_out,
  output logic        nVMA_out,
  input  logic        nDTACK_in,
  input  logic        nVPA_in,
  input  logic        nBERR_in,
  input  logic        E_in,
  input  logic [15:0] D_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STRB,
    S_WAIT,
    S_VPAW,
    S_VMA,
    S_TERM,
    S_RECOV
  } state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [1:0]  be_q, be_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        nas_q, nas_d;
  logic        nuds_q, nuds_d;
  logic        nlds_q, nlds_d;
  logic        nwe_q, nwe_d;
  logic        nvma_q, nvma_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        e_q, e_d;

  // Per-cycle helpers for the wait states
  logic [7:0]  cnt_inc;
  logic        tmo_hit;
  logic        do_term;
  logic        do_abort;

  // Next-state and next-output logic; TERM/abort actions are applied on the
  // edge that enters TERM/RECOV so ACK/ERR are high in that state's cycle.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    be_d     = be_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    nas_d    = nas_q;
    nuds_d   = nuds_q;
    nlds_d   = nlds_q;
    nwe_d    = nwe_q;
    nvma_d   = nvma_q;
    cnt_d    = cnt_q;
    e_d      = E_in;
    do_term  = 1'b0;
    do_abort = 1'b0;

    // Saturating increment: the timeout counter must never wrap back to 0
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    tmo_hit = (cnt_inc >= TIMEOUT);

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          state_d = S_ADDR;
          rw_d    = RW;
          be_d    = BE;
          addr_d  = ADDR;
          dout_d  = WDATA;
          nwe_d   = RW;
          busy_d  = 1'b1;
        end
      end

      S_ADDR: begin
        state_d = S_STRB;
        nas_d   = 1'b0;
        if (rw_q) begin
          nuds_d = ~be_q[1];
          nlds_d = ~be_q[0];
        end else begin
          doe_d = 1'b1;
        end
      end

      S_STRB: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
        if (!rw_q) begin
          nuds_d = ~be_q[1];
          nlds_d = ~be_q[0];
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        if (!nBERR_in) begin
          do_abort = 1'b1;
        end else if (!nDTACK_in) begin
          do_term = 1'b1;
        end else if (!nVPA_in) begin
          state_d = S_VPAW;
        end else if (tmo_hit) begin
          do_abort = 1'b1;
        end
      end

      S_VPAW: begin
        cnt_d = cnt_inc;
        if (!e_q && E_in) begin
          nvma_d  = 1'b0;
          state_d = S_VMA;
        end else if (tmo_hit) begin
          do_abort = 1'b1;
        end
      end

      S_VMA: begin
        cnt_d = cnt_inc;
        if (e_q && !E_in) begin
          do_term = 1'b1;
        end else if (tmo_hit) begin
          do_abort = 1'b1;
        end
      end

      S_TERM: begin
        state_d = S_RECOV;
      end

      S_RECOV: begin
        if (nDTACK_in && nVPA_in && nBERR_in) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          nwe_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_term) begin
      state_d = S_TERM;
      ack_d   = 1'b1;
      if (rw_q) begin
        rdata_d = D_in;
      end
      nas_d   = 1'b1;
      nuds_d  = 1'b1;
      nlds_d  = 1'b1;
      nvma_d  = 1'b1;
      doe_d   = 1'b0;
    end

    if (do_abort) begin
      state_d = S_RECOV;
      err_d   = 1'b1;
      nas_d   = 1'b1;
      nuds_d  = 1'b1;
      nlds_d  = 1'b1;
      nvma_d  = 1'b1;
      doe_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset; reset wins mid-cycle
  always_ff @(posedge CLK_FSB) begin
    if (RESET) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      be_q    <= 2'b00;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
      addr_q  <= 23'h000000;
      dout_q  <= 16'h0000;
      doe_q   <= 1'b0;
      nas_q   <= 1'b1;
      nuds_q  <= 1'b1;
      nlds_q  <= 1'b1;
      nwe_q   <= 1'b1;
      nvma_q  <= 1'b1;
      cnt_q   <= 8'd0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      nas_q   <= nas_d;
      nuds_q  <= nuds_d;
      nlds_q  <= nlds_d;
      nwe_q   <= nwe_d;
      nvma_q  <= nvma_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
    end
  end

  assign BUSY     = busy_q;
  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign A_out    = addr_q;
  assign D_out    = dout_q;
  assign D_OE     = doe_q;
  assign nAS_out  = nas_q;
  assign nUDS_out = nuds_q;
  assign nLDS_out = nlds_q;
  assign nWE_out  = nwe_q;
  assign nVMA_out = nvma_q;

endmodule

// File: tb/tb_fsb_master.sv
// Directed bench for fsb_master. Instance dut uses the default TIMEOUT;
// instance dut_t (TIMEOUT=8) is only requested in the timeout scenario.
module tb_fsb_master;

  logic        CLK_FSB;
  logic        RESET;
  logic        REQ, REQ_t;
  logic        RW;
  logic [1:0]  BE;
  logic [22:0] ADDR;
  logic [15:0] WDATA;
  logic        nDTACK, nVPA, nBERR, E;
  logic [15:0] D_in;

  logic        BUSY, ACK, ERR, D_OE, nAS, nUDS, nLDS, nWE, nVMA;
  logic [15:0] RDATA, D_out;
  logic [22:0] A_out;
  logic        BUSY_t, ACK_t, ERR_t, D_OE_t, nAS_t, nUDS_t, nLDS_t, nWE_t, nVMA_t;
  logic [15:0] RDATA_t, D_out_t;
  logic [22:0] A_out_t;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  fsb_master dut (
    .CLK_FSB(CLK_FSB), .RESET(RESET), .REQ(REQ), .RW(RW), .BE(BE), .ADDR(ADDR),
    .WDATA(WDATA), .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .A_out(A_out),
    .D_out(D_out), .D_OE(D_OE), .nAS_out(nAS), .nUDS_out(nUDS), .nLDS_out(nLDS),
    .nWE_out(nWE), .nVMA_out(nVMA), .nDTACK_in(nDTACK), .nVPA_in(nVPA),
    .nBERR_in(nBERR), .E_in(E), .D_in(D_in)
  );

  fsb_master #(.TIMEOUT(8'd8)) dut_t (
    .CLK_FSB(CLK_FSB), .RESET(RESET), .REQ(REQ_t), .RW(RW), .BE(BE), .ADDR(ADDR),
    .WDATA(WDATA), .BUSY(BUSY_t), .ACK(ACK_t), .ERR(ERR_t), .RDATA(RDATA_t),
    .A_out(A_out_t), .D_out(D_out_t), .D_OE(D_OE_t), .nAS_out(nAS_t),
    .nUDS_out(nUDS_t), .nLDS_out(nLDS_t), .nWE_out(nWE_t), .nVMA_out(nVMA_t),
    .nDTACK_in(nDTACK), .nVPA_in(nVPA), .nBERR_in(nBERR), .E_in(E), .D_in(D_in)
  );

  initial CLK_FSB = 1'b0;
  always #5 CLK_FSB = ~CLK_FSB;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge CLK_FSB);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    n_checks++;
    if ({BUSY, ACK, ERR, D_OE, nAS, nUDS, nLDS, nWE, nVMA} !== 9'b0000_11111) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000011111", {BUSY, ACK, ERR, D_OE, nAS, nUDS, nLDS, nWE, nVMA});
    end
    n_checks++;
    if ({RDATA, A_out, D_out} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", RDATA, A_out, D_out);
    end
    n_checks++;
    if ({BUSY_t, ACK_t, ERR_t, D_OE_t, nAS_t, nUDS_t, nLDS_t, nWE_t, nVMA_t} !== 9'b0000_11111) begin
      n_fail++;
      $display("FAIL reset_ctrl_t: got %b expected 000011111", {BUSY_t, ACK_t, ERR_t, D_OE_t, nAS_t, nUDS_t, nLDS_t, nWE_t, nVMA_t});
    end
  endtask

  task automatic test_read();
    int ack_cnt, ack_clk, err_cnt, nas_cnt;
    ack_cnt = 0; ack_clk = 0; err_cnt = 0; nas_cnt = 0;
    REQ = 1'b1; RW = 1'b1; BE = 2'b11; ADDR = 23'h200000; D_in = 16'hA55A;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (ACK) begin ack_cnt++; ack_clk = c; end
      if (ERR) err_cnt++;
      if (ACK && ERR) overlap++;
      if (!nAS) nas_cnt++;
      if (c == 1) begin
        REQ = 1'b0;
        n_checks++;
        if ({BUSY, nWE, nAS, A_out} !== {3'b111, 23'h200000}) begin
          n_fail++;
          $display("FAIL read_accept: got busy/nwe/nas=%b%b%b addr=%h expected 111 200000", BUSY, nWE, nAS, A_out);
        end
      end
      if (c == 2) begin
        nDTACK = 1'b0;
        n_checks++;
        if ({nAS, nUDS, nLDS} !== 3'b000) begin
          n_fail++;
          $display("FAIL read_strobes: got %b expected 000", {nAS, nUDS, nLDS});
        end
      end
      if (c == 4) nDTACK = 1'b1;
    end
    n_checks++;
    if (ack_cnt !== 1 || ack_clk !== 4) begin
      n_fail++;
      $display("FAIL read_ack: got count %0d clock %0d expected 1 at 4", ack_cnt, ack_clk);
    end
    n_checks++;
    if (RDATA !== 16'hA55A) begin
      n_fail++;
      $display("FAIL read_rdata: got %h expected a55a", RDATA);
    end
    n_checks++;
    if (nas_cnt !== 2) begin
      n_fail++;
      $display("FAIL read_nas_width: got %0d expected 2", nas_cnt);
    end
    n_checks++;
    if (err_cnt !== 0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL read_end: got err %0d busy %b expected 0 0", err_cnt, BUSY);
    end
  endtask

  task automatic test_write();
    int ack_cnt, ack_clk, err_cnt, nas_first, lds_first, uds_cnt, doe_cnt, doe_at_ack;
    ack_cnt = 0; ack_clk = 0; err_cnt = 0; nas_first = 0; lds_first = 0;
    uds_cnt = 0; doe_cnt = 0; doe_at_ack = 0;
    REQ = 1'b1; RW = 1'b0; BE = 2'b01; ADDR = 23'h012345; WDATA = 16'h00C3;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (ACK) begin ack_cnt++; ack_clk = c; if (D_OE) doe_at_ack++; end
      if (ERR) err_cnt++;
      if (ACK && ERR) overlap++;
      if (!nAS && nas_first == 0) nas_first = c;
      if (!nLDS && lds_first == 0) lds_first = c;
      if (!nUDS) uds_cnt++;
      if (D_OE) doe_cnt++;
      if (c == 1) begin
        REQ = 1'b0;
        n_checks++;
        if (nWE !== 1'b0) begin
          n_fail++;
          $display("FAIL write_nwe: got %b expected 0", nWE);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (D_out !== 16'h00C3) begin
          n_fail++;
          $display("FAIL write_dout: got %h expected 00c3", D_out);
        end
      end
      if (c == 5) nDTACK = 1'b0;
      if (c == 6) nDTACK = 1'b1;
    end
    n_checks++;
    if (nas_first !== 2 || lds_first !== 3) begin
      n_fail++;
      $display("FAIL write_strobe_order: got nas %0d lds %0d expected 2 3", nas_first, lds_first);
    end
    n_checks++;
    if (uds_cnt !== 0) begin
      n_fail++;
      $display("FAIL write_uds: got %0d low clocks expected 0", uds_cnt);
    end
    n_checks++;
    if (doe_cnt !== 4 || doe_at_ack !== 0) begin
      n_fail++;
      $display("FAIL write_doe: got %0d clocks, %0d at ack expected 4, 0", doe_cnt, doe_at_ack);
    end
    n_checks++;
    if (ack_cnt !== 1 || ack_clk !== 6 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL write_ack: got count %0d clock %0d err %0d expected 1 6 0", ack_cnt, ack_clk, err_cnt);
    end
  endtask

  task automatic test_vpa();
    int ack_cnt, ack_clk, err_cnt, vma_first, vma_cnt;
    ack_cnt = 0; ack_clk = 0; err_cnt = 0; vma_first = 0; vma_cnt = 0;
    REQ = 1'b1; RW = 1'b1; BE = 2'b10; ADDR = 23'h000400; D_in = 16'h1234; E = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (ACK) begin ack_cnt++; ack_clk = c; end
      if (ERR) err_cnt++;
      if (ACK && ERR) overlap++;
      if (!nVMA) begin vma_cnt++; if (vma_first == 0) vma_first = c; end
      if (c == 1) REQ = 1'b0;
      if (c == 2) nVPA = 1'b0;
      if (c == 11) nVPA = 1'b1;
      E = ((c / 5) % 2) == 1;
    end
    E = 1'b0;
    n_checks++;
    if (vma_first !== 6 || vma_cnt !== 5) begin
      n_fail++;
      $display("FAIL vpa_vma: got first %0d width %0d expected 6 5", vma_first, vma_cnt);
    end
    n_checks++;
    if (ack_cnt !== 1 || ack_clk !== 11 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL vpa_ack: got count %0d clock %0d err %0d expected 1 11 0", ack_cnt, ack_clk, err_cnt);
    end
    n_checks++;
    if (RDATA !== 16'h1234 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL vpa_end: got rdata %h busy %b expected 1234 0", RDATA, BUSY);
    end
  endtask

  task automatic test_berr_dtack();
    int ack_cnt, err_cnt, err_clk;
    ack_cnt = 0; err_cnt = 0; err_clk = 0;
    REQ = 1'b1; RW = 1'b1; BE = 2'b11; ADDR = 23'h000800; D_in = 16'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (ACK) ack_cnt++;
      if (ERR) begin err_cnt++; err_clk = c; end
      if (ACK && ERR) overlap++;
      if (c == 1) REQ = 1'b0;
      if (c == 2) begin nBERR = 1'b0; nDTACK = 1'b0; end
      if (c == 4) begin
        nBERR = 1'b1; nDTACK = 1'b1;
        n_checks++;
        if ({nAS, nUDS, nLDS} !== 3'b111) begin
          n_fail++;
          $display("FAIL berr_strobes: got %b expected 111", {nAS, nUDS, nLDS});
        end
      end
    end
    n_checks++;
    if (err_cnt !== 1 || err_clk !== 4 || ack_cnt !== 0) begin
      n_fail++;
      $display("FAIL berr_term: got err %0d at %0d ack %0d expected 1 at 4, 0", err_cnt, err_clk, ack_cnt);
    end
    n_checks++;
    if (RDATA !== 16'h1234 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL berr_end: got rdata %h busy %b expected 1234 0", RDATA, BUSY);
    end
  endtask

  task automatic test_timeout();
    int ack_cnt, err_cnt, err_clk;
    logic busy_at_err, nas_before;
    ack_cnt = 0; err_cnt = 0; err_clk = 0; busy_at_err = 1'b0; nas_before = 1'b1;
    REQ_t = 1'b1; RW = 1'b1; BE = 2'b11; ADDR = 23'h001000;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (ACK_t) ack_cnt++;
      if (ERR_t) begin err_cnt++; err_clk = c; busy_at_err = BUSY_t; end
      if (ACK_t && ERR_t) overlap++;
      if (c == 10) nas_before = nAS_t;
      if (c == 11) begin
        n_checks++;
        if ({nAS_t, nUDS_t, nLDS_t, D_OE_t} !== 4'b1110) begin
          n_fail++;
          $display("FAIL timeout_strobes: got %b expected 1110", {nAS_t, nUDS_t, nLDS_t, D_OE_t});
        end
      end
      if (c == 1) REQ_t = 1'b0;
    end
    n_checks++;
    if (err_cnt !== 1 || err_clk !== 11 || ack_cnt !== 0) begin
      n_fail++;
      $display("FAIL timeout_err: got err %0d at %0d ack %0d expected 1 at 11, 0", err_cnt, err_clk, ack_cnt);
    end
    n_checks++;
    if (nas_before !== 1'b0 || busy_at_err !== 1'b1 || BUSY_t !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: got nas@10 %b busy@err %b busy_end %b expected 0 1 0", nas_before, busy_at_err, BUSY_t);
    end
  endtask

  task automatic test_reset_mid();
    int ack_cnt, err_cnt, ack_clk;
    ack_cnt = 0; err_cnt = 0; ack_clk = 0;
    REQ = 1'b1; RW = 1'b0; BE = 2'b11; ADDR = 23'h7FFFFF; WDATA = 16'hFFFF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ACK) ack_cnt++;
      if (ERR) err_cnt++;
      if (c == 1) REQ = 1'b0;
      if (c == 4) begin
        n_checks++;
        if ({nAS, nUDS, nLDS, D_OE} !== 4'b0001) begin
          n_fail++;
          $display("FAIL rstmid_pre: got %b expected 0001", {nAS, nUDS, nLDS, D_OE});
        end
        RESET = 1'b1;
      end
      if (c == 5) begin
        RESET = 1'b0;
        n_checks++;
        if ({nAS, nUDS, nLDS, nVMA, nWE, BUSY, ACK, ERR, D_OE} !== 9'b11111_0000) begin
          n_fail++;
          $display("FAIL rstmid_outputs: got %b expected 111110000", {nAS, nUDS, nLDS, nVMA, nWE, BUSY, ACK, ERR, D_OE});
        end
        n_checks++;
        if ({A_out, D_out, RDATA} !== 55'd0) begin
          n_fail++;
          $display("FAIL rstmid_data: got %h/%h/%h expected 0/0/0", A_out, D_out, RDATA);
        end
      end
    end
    n_checks++;
    if (ack_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL rstmid_noterm: got ack %0d err %0d expected 0 0", ack_cnt, err_cnt);
    end
    ack_cnt = 0;
    REQ = 1'b1; RW = 1'b1; BE = 2'b01; ADDR = 23'h000010; D_in = 16'h5AA5;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (ACK) begin ack_cnt++; ack_clk = c; end
      if (ACK && ERR) overlap++;
      if (c == 1) REQ = 1'b0;
      if (c == 2) nDTACK = 1'b0;
      if (c == 4) nDTACK = 1'b1;
    end
    n_checks++;
    if (ack_cnt !== 1 || ack_clk !== 4 || RDATA !== 16'h5AA5) begin
      n_fail++;
      $display("FAIL rstmid_after: got ack %0d at %0d rdata %h expected 1 at 4 5aa5", ack_cnt, ack_clk, RDATA);
    end
  endtask

  task automatic test_back_to_back();
    int ack_cnt, ack1, ack2;
    logic busy6, busy7;
    logic [22:0] a3, a8;
    ack_cnt = 0; ack1 = 0; ack2 = 0; busy6 = 1'b1; busy7 = 1'b0; a3 = '0; a8 = '0;
    REQ = 1'b1; RW = 1'b1; BE = 2'b11; ADDR = 23'h0ABCDE; D_in = 16'h0F0F;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ACK) begin
        ack_cnt++;
        if (ack1 == 0) ack1 = c; else ack2 = c;
      end
      if (ACK && ERR) overlap++;
      if (c == 1) ADDR = 23'h054321;
      if (c == 3) a3 = A_out;
      if (c == 6) busy6 = BUSY;
      if (c == 7) begin busy7 = BUSY; REQ = 1'b0; end
      if (c == 8) a8 = A_out;
      nDTACK = nAS;
    end
    nDTACK = 1'b1;
    n_checks++;
    if (ack_cnt !== 2 || ack1 !== 4 || ack2 !== 10) begin
      n_fail++;
      $display("FAIL b2b_acks: got %0d at %0d,%0d expected 2 at 4,10", ack_cnt, ack1, ack2);
    end
    n_checks++;
    if (busy6 !== 1'b0 || busy7 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: got c6 %b c7 %b expected 0 1", busy6, busy7);
    end
    n_checks++;
    if (a3 !== 23'h0ABCDE || a8 !== 23'h054321) begin
      n_fail++;
      $display("FAIL b2b_addr: got %h %h expected 0abcde 054321", a3, a8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; REQ = 1'b0; REQ_t = 1'b0; RW = 1'b1; BE = 2'b11;
    ADDR = '0; WDATA = '0; nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
    E = 1'b0; D_in = '0;
    test_reset();
    test_read();
    test_write();
    test_vpa();
    test_berr_dtack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL ack_err_overlap: got %0d cycles expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
